// File: rtl/fft_pkg.sv
// Shared types and elaboration-time helpers for the FFT twiddle path.
package fft_pkg;

  localparam int unsigned TW_WIDTH = 8;
  localparam int unsigned TW_CW    = TW_WIDTH / 2;

  // One twiddle beat as seen on the bus: imaginary part in the upper half.
  typedef struct packed {
    logic signed [TW_CW-1:0] im;
    logic signed [TW_CW-1:0] re;
  } twiddle_t;

  // Fixed-point constants for the cosine series (30 fractional bits).
  localparam int unsigned FX_FRAC = 30;
  localparam longint      FX_ONE  = 64'sd1 << FX_FRAC;
  localparam longint      PI_FX   = 64'sd3373259426;

  // Ceiling log2 of n.
  function automatic int unsigned log2n(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  // Entry idx of the quarter-wave table: round(cos(2*pi*idx/n) * 2^(cw-1)),
  // clamped to the largest positive Q1.(cw-1) value so +1.0 never wraps.
  function automatic int unsigned quarter_cos_table(input int unsigned n,
                                                    input int unsigned cw,
                                                    input int unsigned idx);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint scaled;
    longint maxq;
    x    = (PI_FX * 64'sd2 * longint'(idx)) / longint'(n);
    x2   = (x * x) >>> FX_FRAC;
    term = FX_ONE;
    sum  = FX_ONE;
    for (int i = 1; i <= 10; i++) begin
      term = -((term * x2) >>> FX_FRAC) / longint'((2 * i - 1) * (2 * i));
      sum  = sum + term;
    end
    scaled = ((sum <<< (cw - 1)) + (FX_ONE >>> 1)) >>> FX_FRAC;
    maxq   = (64'sd1 <<< (cw - 1)) - 64'sd1;
    if (scaled > maxq) scaled = maxq;
    if (scaled < 64'sd0) scaled = 64'sd0;
    return 32'(scaled);
  endfunction

endpackage

// File: rtl/twiddle_quarter_rom.sv
// Combinational quarter-wave cosine ROM, N/4+1 entries of CW bits.
module twiddle_quarter_rom
  import fft_pkg::*;
#(
  parameter int unsigned SAMPLES = 8,
  parameter int unsigned CW      = 4,
  parameter int unsigned AW      = 2
) (
  input  logic [AW-1:0] addr,
  output logic [CW-1:0] q_c
);

  localparam int unsigned ENTRIES = SAMPLES / 4 + 1;

  logic [CW-1:0] table_q [ENTRIES];

  for (genvar g = 0; g < ENTRIES; g++) begin : g_entry
    localparam int unsigned QV = quarter_cos_table(SAMPLES, CW, g);
    assign table_q[g] = CW'(QV);
  end

  // Table lookup; addresses past the last entry read as zero.
  always_comb begin
    q_c = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      if (32'(addr) == i) q_c = table_q[i];
    end
  end

endmodule

// File: rtl/twiddle_stream_gen.sv
// Streams the N/2 twiddles of one radix-2 DIT stage in butterfly order.
module twiddle_stream_gen
  import fft_pkg::*;
#(
  parameter  int unsigned SAMPLES = 8,
  parameter  int unsigned WIDTH   = 8,
  localparam int unsigned L       = log2n(SAMPLES),
  localparam int unsigned SW      = (L > 1) ? $clog2(L) : 1,
  localparam int unsigned KW      = L - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SW-1:0]    stage,
  input  logic             conj,
  output logic             busy,
  output logic             stage_err,
  output logic             tw_valid,
  input  logic             tw_ready,
  output logic [WIDTH-1:0] tw_data,
  output logic [KW-1:0]    tw_index,
  output logic             tw_last
);

  localparam int unsigned CW   = WIDTH / 2;
  localparam int unsigned HALF = SAMPLES / 2;
  localparam int unsigned QN   = SAMPLES / 4;
  localparam int unsigned AW   = $clog2(QN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          load_c;
  logic          en_c;
  logic          issue_c;
  logic          bad_stage_c;
  logic          cnt_last_c;
  logic [KW-1:0] cnt;
  logic [SW-1:0] stage_q;
  logic          conj_q;
  logic [KW-1:0] k_c;
  logic          fold_c;
  logic          s1_valid;
  logic          s1_last;
  logic          s1_fold;
  logic [KW-1:0] s1_k;
  logic [AW-1:0] cos_addr_c;
  logic [AW-1:0] sin_addr_c;
  logic [CW-1:0] cos_q_c;
  logic [CW-1:0] sin_q_c;
  logic [CW-1:0] re_c;
  logic [CW-1:0] im_c;

  assign en_c        = !tw_valid || tw_ready;
  assign issue_c     = (state == RUN) && en_c;
  assign bad_stage_c = 32'(stage) >= L;
  assign cnt_last_c  = (cnt == KW'(HALF - 1));

  // k = (cnt & (2^s - 1)) << (L-1-s)
  assign k_c    = KW'((32'(cnt) & ((32'd1 << stage_q) - 32'd1)) << (32'(L - 1) - 32'(stage_q)));
  assign fold_c = 32'(k_c) > QN;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; a valid start is the only way out of IDLE.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !bad_stage_c) begin
          state_nxt = RUN;
          load_c    = 1'b1;
        end
      end
      RUN: begin
        if (en_c && cnt_last_c) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (tw_valid && tw_ready && tw_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter, latched sequence parameters and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      stage_q   <= '0;
      conj_q    <= 1'b0;
      busy      <= 1'b0;
      stage_err <= 1'b0;
    end else begin
      busy      <= (state_nxt != IDLE);
      stage_err <= (state == IDLE) && start && bad_stage_c;
      if (load_c) begin
        cnt     <= '0;
        stage_q <= stage;
        conj_q  <= conj;
      end else if (issue_c) begin
        cnt <= cnt + KW'(1);
      end
    end
  end

  // S1: angle index and fold select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_fold  <= 1'b0;
      s1_k     <= '0;
    end else if (en_c) begin
      s1_valid <= issue_c;
      s1_last  <= cnt_last_c;
      s1_fold  <= fold_c;
      s1_k     <= k_c;
    end
  end

  // Symmetry folding onto the quarter-wave table.
  always_comb begin
    cos_addr_c = AW'(32'(s1_k));
    sin_addr_c = AW'(QN - 32'(s1_k));
    if (s1_fold) begin
      cos_addr_c = AW'(HALF - 32'(s1_k));
      sin_addr_c = AW'(32'(s1_k) - QN);
    end
  end

  twiddle_quarter_rom #(.SAMPLES(SAMPLES), .CW(CW), .AW(AW)) u_cos_rom (
    .addr (cos_addr_c),
    .q_c  (cos_q_c)
  );

  twiddle_quarter_rom #(.SAMPLES(SAMPLES), .CW(CW), .AW(AW)) u_sin_rom (
    .addr (sin_addr_c),
    .q_c  (sin_q_c)
  );

  // Second-quadrant cosine is negative; conjugation flips the sine sign.
  assign re_c = s1_fold ? (-cos_q_c) : cos_q_c;
  assign im_c = conj_q  ? (-sin_q_c) : sin_q_c;

  // S2: output beat register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tw_valid <= 1'b0;
      tw_data  <= '0;
      tw_index <= '0;
      tw_last  <= 1'b0;
    end else if (en_c) begin
      tw_valid <= s1_valid;
      tw_last  <= s1_valid && s1_last;
      if (s1_valid) begin
        tw_data  <= WIDTH'({im_c, re_c});
        tw_index <= s1_k;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_stream_gen.sv
// Directed bench for twiddle_stream_gen, N=8, WIDTH=8 (Q = {7,6,0}).
module tb_twiddle_stream_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] stage;
  logic       conj;
  logic       busy;
  logic       stage_err;
  logic       tw_valid;
  logic       tw_ready;
  logic [7:0] tw_data;
  logic [1:0] tw_index;
  logic       tw_last;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] got_data [16];
  logic [1:0] got_idx  [16];
  logic       got_last [16];
  int         got_cyc  [16];
  int         got_n;
  int         hold_bad;
  int         busy_bad;
  int         timeout;
  logic       busy_after;
  logic       valid_after;

  always #5 clk = ~clk;

  twiddle_stream_gen #(.SAMPLES(8), .WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stage     (stage),
    .conj      (conj),
    .busy      (busy),
    .stage_err (stage_err),
    .tw_valid  (tw_valid),
    .tw_ready  (tw_ready),
    .tw_data   (tw_data),
    .tw_index  (tw_index),
    .tw_last   (tw_last)
  );

  // Pulse start for one clock; returns at the negedge after the start edge.
  task automatic issue_start(input logic [1:0] s, input logic c);
    @(negedge clk);
    start = 1'b1;
    stage = s;
    conj  = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Capture beats until tw_last handshakes; optional stall and stray start.
  task automatic collect(input int stall_beat, input int stall_len, input int inject_cyc);
    int         cyc;
    int         stalled;
    logic [7:0] hd;
    logic [1:0] hi;
    logic       hl;
    bit         done;
    for (int i = 0; i < 16; i++) begin
      got_data[i] = 'x;
      got_idx[i]  = 'x;
      got_last[i] = 1'bx;
      got_cyc[i]  = -1;
    end
    got_n = 0; hold_bad = 0; busy_bad = 0; timeout = 0;
    cyc = 0; stalled = 0; done = 0;
    hd = '0; hi = '0; hl = 1'b0;
    while (!done) begin
      start = (cyc == inject_cyc);
      if (start) begin
        stage = 2'd1;
        conj  = 1'b1;
      end
      if (busy !== 1'b1) busy_bad++;
      if (tw_valid === 1'b1 && got_n == stall_beat && stalled < stall_len) begin
        if (stalled == 0) begin
          hd = tw_data; hi = tw_index; hl = tw_last;
        end else if (tw_data !== hd || tw_index !== hi || tw_last !== hl) begin
          hold_bad++;
        end
        tw_ready = 1'b0;
        stalled++;
      end else begin
        if (stalled > 0 && got_n == stall_beat &&
            (tw_valid !== 1'b1 || tw_data !== hd || tw_index !== hi || tw_last !== hl))
          hold_bad++;
        tw_ready = 1'b1;
        if (tw_valid === 1'b1) begin
          if (got_n < 16) begin
            got_data[got_n] = tw_data;
            got_idx[got_n]  = tw_index;
            got_last[got_n] = tw_last;
            got_cyc[got_n]  = cyc;
          end
          got_n++;
          if (tw_last === 1'b1) done = 1;
        end
      end
      @(negedge clk);
      cyc++;
      if (cyc > 40) begin
        timeout = 1;
        done    = 1;
      end
    end
    start       = 1'b0;
    tw_ready    = 1'b1;
    busy_after  = busy;
    valid_after = tw_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; stage = '0; conj = 1'b0; tw_ready = 1'b1;
    #1;
    vectors++;
    if ({busy, stage_err, tw_valid, tw_data, tw_index, tw_last} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got busy=%b err=%b v=%b d=%h i=%0d l=%b want all 0",
               busy, stage_err, tw_valid, tw_data, tw_index, tw_last);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (tw_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release got v=%b busy=%b want 0 0", tw_valid, busy);
    end
  endtask

  task automatic test_forward;
    logic [7:0] ed [4];
    ed[0] = 8'h07; ed[1] = 8'h66; ed[2] = 8'h70; ed[3] = 8'h6A;
    issue_start(2'd2, 1'b0);
    collect(-1, 0, -1);
    vectors++;
    if (got_n != 4 || timeout != 0) begin
      miscompares++;
      $display("FAIL fwd_count got %0d beats timeout=%0d want 4 beats", got_n, timeout);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_data[i] !== ed[i] || got_idx[i] !== 2'(i) || got_last[i] !== (i == 3)) begin
        miscompares++;
        $display("FAIL fwd_beat%0d got d=%h i=%0d l=%b want d=%h i=%0d l=%b",
                 i, got_data[i], got_idx[i], got_last[i], ed[i], i, (i == 3));
      end
      vectors++;
      if (got_cyc[i] != 2 + i) begin
        miscompares++;
        $display("FAIL fwd_timing%0d got cycle %0d want %0d", i, got_cyc[i], 2 + i);
      end
    end
    vectors++;
    if (busy_bad != 0 || busy_after !== 1'b0 || valid_after !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd_busy got drops=%0d after=%b v_after=%b want 0 0 0",
               busy_bad, busy_after, valid_after);
    end
  endtask

  task automatic test_conj;
    logic [7:0] ed [4];
    ed[0] = 8'h07; ed[1] = 8'hA6; ed[2] = 8'h90; ed[3] = 8'hAA;
    issue_start(2'd2, 1'b1);
    collect(-1, 0, -1);
    vectors++;
    if (got_n != 4 || timeout != 0) begin
      miscompares++;
      $display("FAIL conj_count got %0d beats timeout=%0d want 4 beats", got_n, timeout);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_data[i] !== ed[i] || got_idx[i] !== 2'(i)) begin
        miscompares++;
        $display("FAIL conj_beat%0d got d=%h i=%0d want d=%h i=%0d",
                 i, got_data[i], got_idx[i], ed[i], i);
      end
    end
  endtask

  task automatic test_stages;
    logic [7:0] ed [4];
    logic [1:0] ei [4];
    ed[0] = 8'h07; ed[1] = 8'h70; ed[2] = 8'h07; ed[3] = 8'h70;
    ei[0] = 2'd0;  ei[1] = 2'd2;  ei[2] = 2'd0;  ei[3] = 2'd2;
    issue_start(2'd1, 1'b0);
    collect(-1, 0, -1);
    vectors++;
    if (got_n != 4 || timeout != 0) begin
      miscompares++;
      $display("FAIL s1_count got %0d beats want 4", got_n);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_data[i] !== ed[i] || got_idx[i] !== ei[i] || got_last[i] !== (i == 3)) begin
        miscompares++;
        $display("FAIL s1_beat%0d got d=%h i=%0d l=%b want d=%h i=%0d l=%b",
                 i, got_data[i], got_idx[i], got_last[i], ed[i], ei[i], (i == 3));
      end
    end
    issue_start(2'd0, 1'b0);
    collect(-1, 0, -1);
    vectors++;
    if (got_n != 4 || timeout != 0) begin
      miscompares++;
      $display("FAIL s0_count got %0d beats want 4", got_n);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_data[i] !== 8'h07 || got_idx[i] !== 2'd0) begin
        miscompares++;
        $display("FAIL s0_beat%0d got d=%h i=%0d want d=07 i=0", i, got_data[i], got_idx[i]);
      end
    end
  endtask

  task automatic test_stall;
    logic [7:0] ed [4];
    ed[0] = 8'h07; ed[1] = 8'h66; ed[2] = 8'h70; ed[3] = 8'h6A;
    issue_start(2'd2, 1'b0);
    collect(1, 3, -1);
    vectors++;
    if (hold_bad != 0) begin
      miscompares++;
      $display("FAIL stall_hold got %0d unstable cycles want 0", hold_bad);
    end
    vectors++;
    if (got_n != 4 || timeout != 0) begin
      miscompares++;
      $display("FAIL stall_count got %0d beats want 4", got_n);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_data[i] !== ed[i] || got_idx[i] !== 2'(i)) begin
        miscompares++;
        $display("FAIL stall_beat%0d got d=%h i=%0d want d=%h i=%0d",
                 i, got_data[i], got_idx[i], ed[i], i);
      end
    end
    vectors++;
    if (got_cyc[1] != 6 || busy_bad != 0 || busy_after !== 1'b0) begin
      miscompares++;
      $display("FAIL stall_busy got beat1_cyc=%0d drops=%0d after=%b want 6 0 0",
               got_cyc[1], busy_bad, busy_after);
    end
  endtask

  task automatic test_errors;
    int stray;
    @(negedge clk);
    start = 1'b1; stage = 2'd3; conj = 1'b0;
    @(negedge clk);
    start = 1'b0;
    vectors++;
    if (stage_err !== 1'b1 || busy !== 1'b0 || tw_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL err_pulse got err=%b busy=%b v=%b want 1 0 0", stage_err, busy, tw_valid);
    end
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (stage_err !== 1'b0 || busy !== 1'b0 || tw_valid !== 1'b0) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL err_after got %0d bad cycles want 0", stray);
    end
    begin
      logic [7:0] ed [4];
      ed[0] = 8'h07; ed[1] = 8'h66; ed[2] = 8'h70; ed[3] = 8'h6A;
      issue_start(2'd2, 1'b0);
      collect(-1, 0, 3);
      vectors++;
      if (got_n != 4 || timeout != 0) begin
        miscompares++;
        $display("FAIL busy_start_count got %0d beats want 4", got_n);
      end
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (got_data[i] !== ed[i] || got_idx[i] !== 2'(i)) begin
          miscompares++;
          $display("FAIL busy_start_beat%0d got d=%h i=%0d want d=%h i=%0d",
                   i, got_data[i], got_idx[i], ed[i], i);
        end
      end
      stray = 0;
      repeat (4) begin
        @(negedge clk);
        if (tw_valid !== 1'b0 || busy !== 1'b0) stray++;
      end
      vectors++;
      if (stray != 0) begin
        miscompares++;
        $display("FAIL busy_start_after got %0d bad cycles want 0", stray);
      end
    end
  endtask

  task automatic test_async_reset;
    int stray;
    logic [7:0] ed [4];
    ed[0] = 8'h07; ed[1] = 8'h66; ed[2] = 8'h70; ed[3] = 8'h6A;
    issue_start(2'd2, 1'b0);
    tw_ready = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (tw_valid !== 1'b1 || tw_data !== 8'h66) begin
      miscompares++;
      $display("FAIL rst_pre got v=%b d=%h want 1 66", tw_valid, tw_data);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (tw_valid !== 1'b0 || busy !== 1'b0 || tw_data !== 8'h00 || tw_last !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async got v=%b busy=%b d=%h l=%b want 0 0 00 0",
               tw_valid, busy, tw_data, tw_last);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (tw_valid !== 1'b0 || busy !== 1'b0) stray++;
    end
    vectors++;
    if (stray != 0) begin
      miscompares++;
      $display("FAIL rst_no_partial got %0d bad cycles want 0", stray);
    end
    issue_start(2'd2, 1'b0);
    collect(-1, 0, -1);
    vectors++;
    if (got_n != 4 || timeout != 0) begin
      miscompares++;
      $display("FAIL rst_replay_count got %0d beats want 4", got_n);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (got_data[i] !== ed[i] || got_idx[i] !== 2'(i) || got_cyc[i] != 2 + i) begin
        miscompares++;
        $display("FAIL rst_replay_beat%0d got d=%h i=%0d cyc=%0d want d=%h i=%0d cyc=%0d",
                 i, got_data[i], got_idx[i], got_cyc[i], ed[i], i, 2 + i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_conj();
    test_stages();
    test_stall();
    test_errors();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
